// File: rtl/mips_mem_access_unit.sv
// -----------------------------------------------------------------------------
// mips_mem_access_unit
//
// Load/store initiator sitting between the MIPS MEM stage and the word-wide
// single-port DataMemory. One byte-addressed request is accepted at a time and
// mapped onto word accesses:
//   - loads          : READ for READ_LATENCY cycles, then respond with the
//                      selected byte/halfword/word, sign- or zero-extended
//   - word stores    : a single WRITE cycle
//   - sub-word stores: READ (fetch the containing word), then a WRITE of the
//                      merged word (read-modify-write)
//   - illegal access : one ERR cycle with no memory traffic, then rsp_err
// Memory is little-endian: byte k of a word is bits [8k+7:8k].
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   request handshake; accept when both are high at an edge
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed        loads only: 1 sign-extends, 0 zero-extends
//   req_addr          byte address (bits above ADDR_W+1 ignored)
//   req_wdata         right-justified store data
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         extended load data (0 for stores and errors)
//   rsp_err           misaligned or illegal-size request
//   mem_addr          word address driven to DataMemory
//   mem_dataIn        write data to DataMemory
//   mem_enable        memory enable
//   mem_we, mem_re    memory write / read enable
//   mem_dataOut       memory read data
// -----------------------------------------------------------------------------
module mips_mem_access_unit #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1   // 1 = LOW_LATENCY memory, 2 = HIGH_PERFORMANCE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_dataIn,
  output logic              mem_enable,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_dataOut
);

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Value of the latency counter on the final READ cycle.
  localparam logic [1:0] LAST_RD_CNT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state;

  // Latched request fields; only the bits the later states consume are kept.
  logic        wr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;      // byte offset within the word
  logic [15:0] wdata_q;    // sub-word store data (word stores go straight out)
  logic [1:0]  lat_cnt;

  logic        req_illegal;

  // Address bits above the word-address field wrap away by design.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // ---------------------------------------------------------------------------
  // Legality of the request presented on the req_* inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    req_illegal = 1'b0;
    case (req_size)
      SIZE_B:  req_illegal = 1'b0;
      SIZE_H:  req_illegal = req_addr[0];
      SIZE_W:  req_illegal = (req_addr[1:0] != 2'b00);
      default: req_illegal = 1'b1;
    endcase
  end

  // Select the addressed field of a read word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_B:  extract_load = {{24{sgn & shifted[7]}},  shifted[7:0]};
      SIZE_H:  extract_load = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: extract_load = word;   // word loads ignore req_signed
    endcase
  endfunction

  // Replace the addressed byte/halfword of a read word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] merged;
    merged = word;
    if (size == SIZE_B) merged[{off, 3'b000} +: 8] = data[7:0];
    else                merged[{off[1], 4'b0000} +: 16] = data;
    return merged;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory strobes decode straight from the state, gated by reset so a WRITE
  // cycle that coincides with reset never reaches the array.
  // ---------------------------------------------------------------------------
  assign req_ready  = (state == IDLE)  && !reset;
  assign mem_re     = (state == READ)  && !reset;
  assign mem_we     = (state == WRITE) && !reset;
  assign mem_enable = mem_re || mem_we;

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: only control state and the visible outputs are reset; the
      // latched request fields are always rewritten on accept before use.
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
      lat_cnt    <= '0;
    end else begin
      rsp_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q     <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= req_addr[ADDR_W+1:2];
            lat_cnt  <= '0;
            if (req_illegal) begin
              state <= ERR;
            end else if (req_write && (req_size == SIZE_W)) begin
              mem_dataIn <= req_wdata;
              state      <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end

        READ: begin
          if (lat_cnt == LAST_RD_CNT) begin
            if (wr_q) begin
              mem_dataIn <= merge_store(mem_dataOut, wdata_q, size_q, off_q);
              state      <= WRITE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= extract_load(mem_dataOut, size_q, signed_q, off_q);
              rsp_err   <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        WRITE: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end

        ERR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_access_unit
//
// Two units share clock and reset: index 0 uses READ_LATENCY=1 against a
// combinational-read memory, index 1 uses READ_LATENCY=2 against a memory with
// a registered read port. Requests are pushed to a per-unit scoreboard with
// the expected response computed from a byte-level memory image; a monitor
// pops and compares on every rsp_valid, including latency and the number of
// read/write/enable cycles seen during the transaction.
// -----------------------------------------------------------------------------
module tb_mips_mem_access_unit;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          re;
    int          we;
    int          en;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;

  logic        req_valid  [2] = '{1'b0, 1'b0};
  logic        req_write  [2] = '{1'b0, 1'b0};
  logic [1:0]  req_size   [2] = '{2'b00, 2'b00};
  logic        req_signed [2] = '{1'b0, 1'b0};
  logic [31:0] req_addr   [2] = '{32'd0, 32'd0};
  logic [31:0] req_wdata  [2] = '{32'd0, 32'd0};
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic [AW-1:0] mem_addr [2];
  logic [31:0] mem_dataIn [2];
  logic        mem_enable [2];
  logic        mem_we     [2];
  logic        mem_re     [2];
  logic [31:0] mem_dataOut[2];

  logic [31:0] ram     [2][WORDS];
  logic [31:0] ref_mem [2][WORDS];
  logic [31:0] dout1_q;

  exp_t        sbq [2][$];
  int          cyc = 0;
  int          acc_cyc [2];
  int          re_n [2], we_n [2], en_n [2];
  logic [31:0] last_din [2];

  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_mem_access_unit #(.ADDR_W(AW), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]), .mem_dataIn(mem_dataIn[0]),
    .mem_enable(mem_enable[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .mem_dataOut(mem_dataOut[0])
  );

  mips_mem_access_unit #(.ADDR_W(AW), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]), .mem_dataIn(mem_dataIn[1]),
    .mem_enable(mem_enable[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .mem_dataOut(mem_dataOut[1])
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h8844_22F0 : (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // DataMemory models: index 0 reads combinationally (data valid at the first
  // edge), index 1 registers the read data (valid at the second edge).
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < WORDS; i++) begin
        ram[0][i] <= init_word(i);
        ram[1][i] <= init_word(i);
      end
    end else begin
      if (mem_enable[0] && mem_we[0]) ram[0][mem_addr[0]] <= mem_dataIn[0];
      if (mem_enable[1] && mem_we[1]) ram[1][mem_addr[1]] <= mem_dataIn[1];
    end
    if (mem_enable[1] && mem_re[1]) dout1_q <= ram[1][mem_addr[1]];
  end
  assign mem_dataOut[0] = ram[0][mem_addr[0]];
  assign mem_dataOut[1] = dout1_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: byte-lane view of memory, applies the request to the
  // image and returns the response the unit owes.
  function automatic exp_t model(input int d, input logic wr, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          nbytes, sh, lat, w;
    logic [31:0] mask, word, f;
    lat    = d + 1;
    w      = int'((a >> 2) % 32'(WORDS));
    sh     = 8 * int'(a % 32'd4);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    word   = ref_mem[d][w];
    if (sz == 2'd3 || (int'(a % 32'd4) % nbytes) != 0) begin
      e = '{rdata: 32'd0, err: 1'b1, lat: 2, re: 0, we: 0, en: 0};
    end else if (!wr) begin
      f = (word >> sh) & mask;
      if (sg && nbytes < 4 && f[8 * nbytes - 1]) f = f | ~mask;
      e = '{rdata: f, err: 1'b0, lat: lat + 1, re: lat, we: 0, en: lat};
    end else begin
      ref_mem[d][w] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      if (nbytes == 4) e = '{rdata: 32'd0, err: 1'b0, lat: 2, re: 0, we: 1, en: 1};
      else             e = '{rdata: 32'd0, err: 1'b0, lat: lat + 2, re: lat, we: 1, en: lat + 1};
    end
    return e;
  endfunction

  // Monitor: compares each response with the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          check($sformatf("d%0d_rsp_expected", d), 32'(sbq[d].size() != 0), 32'd1);
          if (sbq[d].size() != 0) begin
            exp_t e;
            e = sbq[d].pop_front();
            check($sformatf("d%0d_rdata", d),   rsp_rdata[d], e.rdata);
            check($sformatf("d%0d_err", d),     32'(rsp_err[d]), 32'(e.err));
            check($sformatf("d%0d_latency", d), 32'(cyc - acc_cyc[d]), 32'(e.lat));
            check($sformatf("d%0d_re_cycles", d), 32'(re_n[d]), 32'(e.re));
            check($sformatf("d%0d_we_cycles", d), 32'(we_n[d]), 32'(e.we));
            check($sformatf("d%0d_en_cycles", d), 32'(en_n[d]), 32'(e.en));
            check($sformatf("d%0d_ready_in_rsp", d), 32'(req_ready[d]), 32'd1);
          end
        end
        if (req_valid[d] && req_ready[d]) begin
          acc_cyc[d] = cyc;
          re_n[d] = 0; we_n[d] = 0; en_n[d] = 0;
        end else begin
          re_n[d] += int'(mem_re[d]);
          we_n[d] += int'(mem_we[d]);
          en_n[d] += int'(mem_enable[d]);
        end
        if (mem_we[d]) last_din[d] = mem_dataIn[d];
      end
    end
  end

  // Drive one request and wait for acceptance; keep=1 leaves req_valid high
  // so the next call issues back-to-back.
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit keep);
    int guard;
    req_write[d] = wr; req_size[d] = sz; req_signed[d] = sg;
    req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!req_ready[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) begin
      check($sformatf("d%0d_accept_timeout", d), 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sbq[d].push_back(model(d, wr, sz, sg, a, wd));
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while (sbq[d].size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check($sformatf("d%0d_drain", d), 32'(sbq[d].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("d%0d_rst_rsp_valid", d),  32'(rsp_valid[d]), 32'd0);
    check($sformatf("d%0d_rst_rsp_rdata", d),  rsp_rdata[d], 32'd0);
    check($sformatf("d%0d_rst_rsp_err", d),    32'(rsp_err[d]), 32'd0);
    check($sformatf("d%0d_rst_mem_addr", d),   32'(mem_addr[d]), 32'd0);
    check($sformatf("d%0d_rst_mem_dataIn", d), mem_dataIn[d], 32'd0);
    check($sformatf("d%0d_rst_enables", d),
          32'({mem_enable[d], mem_we[d], mem_re[d]}), 32'd0);
    check($sformatf("d%0d_rst_ready", d),      32'(req_ready[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          guard, mism;
    logic [1:0]  sz;
    logic [31:0] a;
    bit          keep;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < WORDS; i++) ref_mem[d][i] = init_word(i);

    // Reset with memory preload.
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Loads on the latency-1 unit: lb, lbu, lh, lhu.
    issue(0, 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 1'b0);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 1'b0);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0);
    issue(0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0);

    // Byte store read-modify-write, then read back the whole word.
    issue(0, 1'b1, 2'b00, 1'b0, 32'h15, 32'h1234_56AB, 1'b0);
    drain(0);
    check("sb_write_data", last_din[0], 32'h8844_ABF0);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);

    // Illegal accesses: misaligned word, misaligned halfword, size 11.
    issue(0, 1'b1, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b0);
    issue(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
    drain(0);

    // Latency-2 unit: word load, halfword store, readback.
    issue(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b01, 1'b0, 32'h14, 32'h0000_BEEF, 1'b0);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
    drain(1);
    check("sh_word_image", ram[1][5], 32'h8844_BEEF);

    // Back-to-back with req_valid held high; 0x1000 wraps to word 0.
    issue(0, 1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hCAFE_0001, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h0BAD_F00D, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h0000, 32'h0, 1'b0);
    drain(0);

    // Randomized traffic on both units over a small word window, with junk
    // in the ignored upper address bits.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
        keep = ($urandom_range(0, 1) == 1) && (i != 149);
        issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, keep);
      end
      drain(d);
    end

    // Reset during the WRITE cycle of a byte store: no write, no response.
    req_write[0] = 1'b1; req_size[0] = 2'b00; req_signed[0] = 1'b0;
    req_addr[0] = 32'h14; req_wdata[0] = 32'h0000_005A; req_valid[0] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!req_ready[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!mem_we[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_write", 32'(mem_we[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs(0);
    check("abort_word_unchanged", ram[0][5], ref_mem[0][5]);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after_reset", 32'(req_ready[0]), 32'd1);
    check("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
    repeat (4) @(posedge clk);
    check("abort_word_still_unchanged", ram[0][5], ref_mem[0][5]);

    // Final memory image comparison against the reference model.
    for (int d = 0; d < 2; d++) begin
      mism = 0;
      for (int i = 0; i < WORDS; i++) if (ram[d][i] !== ref_mem[d][i]) mism++;
      check($sformatf("d%0d_mem_image_mismatches", d), 32'(mism), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_access_unit.md
Name: mips_mem_access_unit

Overview:
Load/store initiator between the MIPS pipeline MEM stage and the word-wide single-port DataMemory. It accepts one byte-addressed load or store request at a time. It maps each request onto word accesses, running read-modify-write for sub-word stores, and returns sign- or zero-extended load data. It reports misaligned or illegal accesses without touching memory.

Parameters:
ADDR_W, 10, word-address width driven to DataMemory; equals its address port width.
READ_LATENCY, 1, edges from first mem_re cycle to valid mem_dataOut; 1 for LOW_LATENCY memory, 2 for HIGH_PERFORMANCE; only 1 and 2 are legal.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: misaligned or illegal size
mem_addr  out  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
mem_dataIn  out  32  write data
mem_enable  out  1  memory enable
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_dataOut  in  32  memory read data

Behaviour:
- Clock clk; reset synchronous, active-high. Reset forces state IDLE and sets rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_dataIn=0. While reset is high, mem_enable, mem_we and mem_re are all 0. The memory array itself is not cleared.
- Endianness is little-endian:
  - byte k of a word is bits [8k+7:8k];
  - a halfword at addr[1]=h is bits [16h+15:16h].
- Address bits above ADDR_W+1 are ignored, so the word address wraps modulo 2^ADDR_W.
- req_ready = (state==IDLE) && !reset.
- A request is accepted at the edge where req_valid && req_ready. At that edge the unit latches req_write, req_size, req_signed, req_addr and req_wdata. Later changes on the req_* inputs have no effect.
- States:
  - IDLE: on accept, go to ERR if the access is illegal. Otherwise go to READ for loads and sub-word stores, or to WRITE for word stores.
  - READ: mem_enable=mem_re=1. Stays READ_LATENCY cycles, tracked by a counter. On the last edge it captures mem_dataOut into a word register. A load then goes to IDLE with the response; a sub-word store goes to WRITE.
  - WRITE: mem_enable=mem_we=1. mem_dataIn is the captured word with the addressed byte or halfword replaced by req_wdata[7:0] or [15:0], or req_wdata itself for word stores. Exactly one cycle, then IDLE with the response.
  - ERR: one cycle with no memory enables, then IDLE with rsp_err=1.
- Illegal access means any of:
  - req_size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=00.
- Response: rsp_valid is high for exactly one cycle, the first IDLE cycle after completion. A new request may be accepted in that same cycle.
- rsp_rdata holds until the next response.
- Load extraction selects the byte or halfword by addr[1:0]:
  - if req_signed, bits above the selected field are filled with the field MSB;
  - otherwise they are 0;
  - for a word load req_signed is ignored.
- Latency from the accepting edge to the rsp_valid cycle:
  - load: READ_LATENCY+1 cycles;
  - word store: 2 cycles;
  - sub-word store: READ_LATENCY+2 cycles;
  - error: 2 cycles.
- mem_we is never asserted for loads or errors. mem_re is never asserted for word stores.
- Reset asserted mid-operation aborts it with no response. Because the write enable is gated, a write whose WRITE cycle coincides with reset is not performed.

Test Plan:
- Preload word 5 = 0x884422F0, READ_LATENCY=1. Run lb 0x17 -> 0xFFFFFF88; lbu 0x14 -> 0x000000F0; lh 0x16 -> 0xFFFF8844; lhu 0x16 -> 0x00008844. Each gives rsp_valid 2 cycles after accept with rsp_err=0.
- sb 0x15, wdata 0x123456AB -> one READ cycle then one WRITE with mem_dataIn 0x8844ABF0. A following lw 0x14 returns 0x8844ABF0.
- sw 0x06 and lh 0x13 -> rsp_err=1, rsp_rdata=0, and no mem_enable/mem_we cycle. A size=11 request also gives rsp_err=1.
- READ_LATENCY=2 with HIGH_PERFORMANCE memory: lw 0x14 -> rsp_valid 3 cycles after accept. sh 0x14, wdata 0xBEEF -> word becomes 0x8844BEEF.
- Back-to-back traffic: hold req_valid high with alternating sw/lw to 0x3FFC and 0x1000 (0x1000 wraps to word 0). req_ready must reassert in each rsp_valid cycle and the loads must return the stored data.
- Assert reset in a sub-word store's WRITE cycle -> memory word unchanged, no rsp_valid, all outputs at reset values, req_ready=1 one cycle after reset deasserts.
